lsu: RTL and testbench

Load-store unit between the single-cycle core datapath and the data memory port. It accepts one load or store per core request, drives the req/gnt/r_valid data bus with word-aligned address, byte enables and lane-shifted write data, and returns sign- or zero-extended load data. It stalls the core through `lsu_busy` until the transaction completes. It also flags misaligned accesses and illegal width encodings without issuing bus traffic.

---
 rtl/lsu_if.sv | 42 ++++
 rtl/lsu.sv | 173 +++++++++++++++++
 tb/tb_lsu.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/lsu_if.sv
//------------------------------------------------------------------------------
// lsu_if : core-side request/response and data-bus signals of the load-store unit
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface lsu_if;
    logic        lsu_req;
    logic        lsu_we;
    logic [2:0]  lsu_funct3;
    logic [31:0] lsu_adr;
    logic [31:0] lsu_wdata;
    logic [31:0] lsu_rdata;
    logic        lsu_done;
    logic        lsu_err;
    logic        lsu_busy;

    logic        data_req;
    logic [31:0] data_adr;
    logic        data_we;
    logic [3:0]  data_be;
    logic [31:0] data_write;
    logic        data_gnt;
    logic        data_r_valid;
    logic [31:0] data_read;

    modport slave (
        input  lsu_req, lsu_we, lsu_funct3, lsu_adr, lsu_wdata,
        output lsu_rdata, lsu_done, lsu_err, lsu_busy,
        output data_req, data_adr, data_we, data_be, data_write,
        input  data_gnt, data_r_valid, data_read
    );

    modport master (
        output lsu_req, lsu_we, lsu_funct3, lsu_adr, lsu_wdata,
        input  lsu_rdata, lsu_done, lsu_err, lsu_busy,
        input  data_req, data_adr, data_we, data_be, data_write,
        output data_gnt, data_r_valid, data_read
    );
endinterface

`default_nettype wire

// File: rtl/lsu.sv
//------------------------------------------------------------------------------
// lsu : load-store unit bridging the core to a req/gnt/r_valid data bus
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module lsu (
    input  wire logic CLK,
    input  wire logic RES,
    lsu_if.slave      bus
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_WAIT_RV = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] adr_q, adr_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  off_q, off_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        w_legal;
    logic        w_misaligned;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_shift;
    logic [31:0] w_load;

    always_comb begin
        w_legal = 1'b0;
        if (bus.lsu_we) begin
            w_legal = (bus.lsu_funct3 == 3'b000) || (bus.lsu_funct3 == 3'b001) ||
                      (bus.lsu_funct3 == 3'b010);
        end else begin
            w_legal = (bus.lsu_funct3 == 3'b000) || (bus.lsu_funct3 == 3'b001) ||
                      (bus.lsu_funct3 == 3'b010) || (bus.lsu_funct3 == 3'b100) ||
                      (bus.lsu_funct3 == 3'b101);
        end

        w_misaligned = 1'b0;
        case (bus.lsu_funct3[1:0])
            2'b01:   w_misaligned = bus.lsu_adr[0];
            2'b10:   w_misaligned = (bus.lsu_adr[1:0] != 2'b00);
            default: w_misaligned = 1'b0;
        endcase

        // Sub-word stores replicate the datum across lanes; byte enables pick the live one.
        w_be    = 4'b1111;
        w_wdata = bus.lsu_wdata;
        case (bus.lsu_funct3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << bus.lsu_adr[1:0];
                w_wdata = {4{bus.lsu_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << bus.lsu_adr[1:0];
                w_wdata = {2{bus.lsu_wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = bus.lsu_wdata;
            end
        endcase
    end

    always_comb begin
        w_shift = bus.data_read >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  w_load = {{24{w_shift[7]}}, w_shift[7:0]};
            3'b001:  w_load = {{16{w_shift[15]}}, w_shift[15:0]};
            3'b100:  w_load = {24'd0, w_shift[7:0]};
            3'b101:  w_load = {16'd0, w_shift[15:0]};
            default: w_load = w_shift;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        adr_d    = adr_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        off_d    = off_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;

        case (state_q)
            S_IDLE: begin
                if (bus.lsu_req) begin
                    if (!w_legal || w_misaligned) begin
                        err_d   = 1'b1;
                        rdata_d = 32'd0;
                        state_d = S_DONE;
                    end else begin
                        adr_d    = {bus.lsu_adr[31:2], 2'b00};
                        we_d     = bus.lsu_we;
                        funct3_d = bus.lsu_funct3;
                        off_d    = bus.lsu_adr[1:0];
                        be_d     = w_be;
                        wdata_d  = w_wdata;
                        err_d    = 1'b0;
                        rdata_d  = 32'd0;
                        state_d  = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (bus.data_gnt) begin
                    state_d = S_WAIT_RV;
                end
            end
            S_WAIT_RV: begin
                if (bus.data_r_valid) begin
                    if (!we_q) begin
                        rdata_d = w_load;
                    end
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            state_q  <= S_IDLE;
            adr_q    <= 32'd0;
            we_q     <= 1'b0;
            funct3_q <= 3'd0;
            off_q    <= 2'd0;
            be_q     <= 4'd0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            adr_q    <= adr_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            off_q    <= off_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign bus.data_req   = (state_q == S_REQ);
    assign bus.data_adr   = adr_q;
    assign bus.data_we    = we_q;
    assign bus.data_be    = be_q;
    assign bus.data_write = wdata_q;
    assign bus.lsu_rdata  = rdata_q;
    assign bus.lsu_err    = err_q;
    assign bus.lsu_done   = (state_q == S_DONE);
    assign bus.lsu_busy   = ((state_q == S_IDLE) && bus.lsu_req) ||
                            (state_q == S_REQ) || (state_q == S_WAIT_RV);
endmodule

`default_nettype wire

// File: tb/tb_lsu.sv
//------------------------------------------------------------------------------
// tb_lsu : directed and randomized accesses against a byte-level reference model
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_lsu;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    lsu_if bus ();

    lsu dut (
        .CLK (clk),
        .RES (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference: works on byte lanes and access size, not on any encoded state.
    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] adr,
                         input logic [31:0] wdata, input logic [31:0] rword,
                         output logic err, output logic [3:0] be,
                         output logic [31:0] wr, output logic [31:0] rd);
        logic legal;
        int   nbytes;
        int   off;
        longint val;
        legal  = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        nbytes = 1 << f3[1:0];
        off    = int'(adr % 4);
        err    = !legal || ((adr % nbytes) != 0);
        be = 4'd0;
        wr = 32'd0;
        rd = 32'd0;
        for (int i = 0; i < 4; i++) begin
            if (i >= off && i < off + nbytes) be[i] = 1'b1;
            wr[i*8 +: 8] = wdata[(i % nbytes)*8 +: 8];
        end
        if (!we && !err) begin
            val = 0;
            for (int j = 0; j < nbytes && j < 4; j++)
                val = val + (longint'(rword[(off+j)*8 +: 8]) << (8*j));
            if (!f3[2] && nbytes < 4 && val >= (longint'(1) << (8*nbytes - 1)))
                val = val - (longint'(1) << (8*nbytes));
            rd = val[31:0];
        end
    endtask

    // Starts and ends at a falling edge with the unit idle.
    task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] adr,
                          input logic [31:0] wdata, input logic [31:0] rword,
                          input int gnt_dly, input int rv_dly);
        logic        e_err;
        logic [3:0]  e_be;
        logic [31:0] e_wr, e_rd;
        model(we, f3, adr, wdata, rword, e_err, e_be, e_wr, e_rd);
        bus.lsu_req    = 1'b1;
        bus.lsu_we     = we;
        bus.lsu_funct3 = f3;
        bus.lsu_adr    = adr;
        bus.lsu_wdata  = wdata;
        #1;
        chk("busy_c0", {31'd0, bus.lsu_busy}, 32'd1);
        tick();
        if (e_err) begin
            chk("err_done", {31'd0, bus.lsu_done}, 32'd1);
            chk("err_flag", {31'd0, bus.lsu_err}, 32'd1);
            chk("err_rdata", bus.lsu_rdata, 32'd0);
            chk("err_noreq", {31'd0, bus.data_req}, 32'd0);
            chk("err_busy", {31'd0, bus.lsu_busy}, 32'd0);
            bus.lsu_req = 1'b0;
            tick();
            chk("err_noreq2", {31'd0, bus.data_req}, 32'd0);
            chk("err_done_pulse", {31'd0, bus.lsu_done}, 32'd0);
            return;
        end
        for (int k = 0; k <= gnt_dly; k++) begin
            chk("req", {31'd0, bus.data_req}, 32'd1);
            chk("adr", bus.data_adr, {adr[31:2], 2'b00});
            chk("we", {31'd0, bus.data_we}, {31'd0, we});
            chk("be", {28'd0, bus.data_be}, {28'd0, e_be});
            chk("write", bus.data_write, e_wr);
            chk("busy_req", {31'd0, bus.lsu_busy}, 32'd1);
            chk("err_clr", {31'd0, bus.lsu_err}, 32'd0);
            chk("rdata_clr", bus.lsu_rdata, 32'd0);
            bus.data_gnt = (k == gnt_dly);
            tick();
        end
        bus.data_gnt = 1'b0;
        for (int k = 0; k <= rv_dly; k++) begin
            chk("req_drop", {31'd0, bus.data_req}, 32'd0);
            chk("busy_wait", {31'd0, bus.lsu_busy}, 32'd1);
            chk("done_early", {31'd0, bus.lsu_done}, 32'd0);
            bus.data_r_valid = (k == rv_dly);
            bus.data_read    = (k == rv_dly) ? rword : $urandom;
            tick();
        end
        bus.data_r_valid = 1'b0;
        bus.data_read    = $urandom;
        chk("done", {31'd0, bus.lsu_done}, 32'd1);
        chk("ok_err", {31'd0, bus.lsu_err}, 32'd0);
        chk("rdata", bus.lsu_rdata, e_rd);
        chk("busy_done", {31'd0, bus.lsu_busy}, 32'd0);
        bus.lsu_req = 1'b0;
        tick();
        chk("done_pulse", {31'd0, bus.lsu_done}, 32'd0);
        chk("rdata_hold", bus.lsu_rdata, e_rd);
    endtask

    initial begin
        logic [2:0]  f3;
        logic [31:0] a;
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        bus.lsu_req = 1'b0; bus.lsu_we = 1'b0; bus.lsu_funct3 = 3'd0;
        bus.lsu_adr = 32'd0; bus.lsu_wdata = 32'd0;
        bus.data_gnt = 1'b0; bus.data_r_valid = 1'b0; bus.data_read = 32'd0;
        tick();
        tick();
        chk("rst_req", {31'd0, bus.data_req}, 32'd0);
        chk("rst_adr", bus.data_adr, 32'd0);
        chk("rst_be", {28'd0, bus.data_be}, 32'd0);
        chk("rst_write", bus.data_write, 32'd0);
        chk("rst_rdata", bus.lsu_rdata, 32'd0);
        chk("rst_done", {31'd0, bus.lsu_done}, 32'd0);
        chk("rst_busy", {31'd0, bus.lsu_busy}, 32'd0);
        rst = 1'b0;
        tick();

        access(1'b0, 3'b010, 32'h100, 32'd0, 32'hDEADBEEF, 0, 0);
        access(1'b0, 3'b000, 32'h103, 32'd0, 32'h80FF0000, 0, 0);
        access(1'b0, 3'b100, 32'h103, 32'd0, 32'h80FF0000, 0, 1);
        access(1'b0, 3'b101, 32'h102, 32'd0, 32'h80FF0000, 1, 0);
        access(1'b1, 3'b000, 32'h201, 32'h000000AB, 32'h0, 4, 0);
        access(1'b0, 3'b010, 32'h102, 32'd0, 32'h0, 0, 0);
        access(1'b1, 3'b001, 32'h301, 32'h1234, 32'h0, 0, 0);
        access(1'b0, 3'b011, 32'h100, 32'd0, 32'h0, 0, 0);

        // Reset while waiting for the response, then a stale r_valid in idle.
        bus.lsu_req = 1'b1; bus.lsu_we = 1'b0; bus.lsu_funct3 = 3'b010;
        bus.lsu_adr = 32'h400; bus.lsu_wdata = 32'd0;
        tick();
        bus.data_gnt = 1'b1;
        tick();
        bus.data_gnt = 1'b0;
        bus.lsu_req  = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("arst_req", {31'd0, bus.data_req}, 32'd0);
        chk("arst_adr", bus.data_adr, 32'd0);
        chk("arst_busy", {31'd0, bus.lsu_busy}, 32'd0);
        chk("arst_done", {31'd0, bus.lsu_done}, 32'd0);
        tick();
        rst = 1'b0;
        bus.data_r_valid = 1'b1;
        bus.data_read    = 32'hCAFEF00D;
        tick();
        bus.data_r_valid = 1'b0;
        chk("stale_done", {31'd0, bus.lsu_done}, 32'd0);
        chk("stale_rdata", bus.lsu_rdata, 32'd0);
        chk("stale_req", {31'd0, bus.data_req}, 32'd0);
        tick();
        access(1'b0, 3'b010, 32'h400, 32'd0, 32'h13579BDF, 0, 0);

        for (int n = 0; n < 200; n++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                a[1:0] = (f3[1:0] == 2'b10) ? 2'b00 :
                         (f3[1:0] == 2'b01) ? {a[1], 1'b0} : a[1:0];
            end
            access(1'($urandom_range(0, 1)), f3, a, $urandom, $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

`default_nettype wire
